// File: rtl/vm_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg
// Shared definitions for the ballot engine:
//   - vm_state_e  : ballot FSM states (idle, post-vote lockout, result display)
//   - MODE_VOTE / MODE_RESULT : encoding of the 'mode' input
// ---------------------------------------------------------------------------
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK   = 2'd1,
        ST_RESULT = 2'd2
    } vm_state_e;

    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

endpackage

// File: rtl/vm_button_qual.sv
// ---------------------------------------------------------------------------
// vm_button_qual
// Per-channel button qualifier. Counts consecutive high samples of a raw pad
// input and emits a single-cycle 'valid' pulse once DEBOUNCE_CYC of them have
// been seen. Another pulse needs the button to go low for at least one cycle.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   button in   raw button, active-high
//   valid  out  one-cycle qualified-press pulse
// ---------------------------------------------------------------------------
module vm_button_qual
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic valid
);

    localparam int             QW     = $clog2(DEBOUNCE_CYC + 2);
    localparam logic [QW-1:0]  TARGET = QW'(DEBOUNCE_CYC);
    localparam logic [QW-1:0]  PAST   = QW'(DEBOUNCE_CYC + 1);

    logic [QW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;

    // The counter parks one above the target so the pulse fires only once per
    // press. 'armed' comes out of reset cleared, so a button held through
    // reset has to be released before it can qualify again.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (!button) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q && (cnt_q != PAST)) begin
            cnt_d = cnt_q + QW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign valid = armed_q && (cnt_q == TARGET);

endmodule

// File: rtl/vm_ballot_core.sv
// ---------------------------------------------------------------------------
// vm_ballot_core
// Top-level ballot engine: NUM_CAND debounced buttons, saturating per-candidate
// tallies, leader/tie tracking, post-vote lockout and a result display mode.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   mode    in   0 = voting, 1 = result display
//   button  in   [NUM_CAND] raw candidate buttons
//   sel     in   [IDX_W] candidate shown in result mode
//   led     out  [LED_W] display bus (ack one-hot in lockout, tally in result)
//   winner  out  [IDX_W] current leader index
//   tie     out  leader's tally shared by another candidate
//   busy    out  lockout in progress
//   rejects out  [CNT_W] saturating count of rejecting cycles
//                (only when VM_REJECT_COUNT_EN is defined)
// ---------------------------------------------------------------------------
module vm_ballot_core
    import vm_pkg::*;
#(
    parameter int NUM_CAND     = 4,
    parameter int CNT_W        = 8,
    parameter int LED_W        = 8,
    parameter int DEBOUNCE_CYC = 10,
    parameter int LOCK_CYC     = 100,
    parameter int IDX_W        = $clog2(NUM_CAND)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] button,
    input  logic [IDX_W-1:0]    sel,
    output logic [LED_W-1:0]    led,
    output logic [IDX_W-1:0]    winner,
    output logic                tie,
    output logic                busy
`ifdef VM_REJECT_COUNT_EN
    ,
    output logic [CNT_W-1:0]    rejects
`endif
);

    localparam int                LOCK_CW   = $clog2(LOCK_CYC + 1);
    localparam logic [LOCK_CW-1:0] LOCK_LAST = LOCK_CW'(LOCK_CYC - 1);

    logic [NUM_CAND-1:0] valid;

    genvar g;
    generate
        for (g = 0; g < NUM_CAND; g++) begin : g_qual
            vm_button_qual #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_qual (
                .clock (clock),
                .reset (reset),
                .button(button[g]),
                .valid (valid[g])
            );
        end
    endgenerate

    vm_state_e            state_q, state_d;
    logic [LOCK_CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]     tally_q [NUM_CAND];
    logic [CNT_W-1:0]     tally_d [NUM_CAND];
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic                 tie_q, tie_d;
    logic [LED_W-1:0]     led_q, led_d;

    logic                 accept;
    logic [IDX_W-1:0]     vote_idx;
    logic [CNT_W-1:0]     vote_tally;
    logic [CNT_W-1:0]     new_tally;
    logic [CNT_W-1:0]     lead_tally;
    logic [CNT_W-1:0]     sel_tally;

    // Decode which candidate is voting and look up the tallies we compare
    // against. Lookups loop over the real candidates so an out-of-range
    // 'sel' naturally reads as zero.
    always_comb begin
        vote_idx   = '0;
        vote_tally = '0;
        lead_tally = '0;
        sel_tally  = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (valid[i]) begin
                vote_idx   = IDX_W'(i);
                vote_tally = tally_q[i];
            end
            if (winner_q == IDX_W'(i)) lead_tally = tally_q[i];
            if (sel == IDX_W'(i))      sel_tally  = tally_q[i];
        end
        new_tally = vote_tally + CNT_W'(1);
        accept    = (state_q == ST_IDLE) && (mode == MODE_VOTE) &&
                    ($countones(valid) == 1);
    end

    // Ballot FSM, tallies, leader tracker and registered LED bus. Result mode
    // overrides everything, including an unfinished lockout.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = '0;
        tally_d    = tally_q;
        winner_d   = winner_q;
        tie_d      = tie_q;
        led_d      = '0;

        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_LOCK;
            ST_LOCK:   if (lock_cnt_q == LOCK_LAST) state_d = ST_IDLE;
            ST_RESULT: if (mode == MODE_VOTE) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (mode == MODE_RESULT) state_d = ST_RESULT;

        if ((state_q == ST_LOCK) && (state_d == ST_LOCK)) begin
            lock_cnt_d = lock_cnt_q + LOCK_CW'(1);
        end

        // A vote at saturation still locks out, but changes no tally or leader.
        if (accept && (vote_tally != '1)) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (vote_idx == IDX_W'(i)) tally_d[i] = new_tally;
            end
            if (new_tally > lead_tally) begin
                winner_d = vote_idx;
                tie_d    = 1'b0;
            end else if ((new_tally == lead_tally) && (vote_idx != winner_q)) begin
                tie_d = 1'b1;
            end
        end

        if (state_d == ST_LOCK) begin
            if (state_q == ST_LOCK) begin
                led_d = led_q;
            end else begin
                for (int i = 0; i < NUM_CAND; i++) begin
                    if (vote_idx == IDX_W'(i)) led_d[i % LED_W] = 1'b1;
                end
            end
        end else if (state_d == ST_RESULT) begin
            led_d = LED_W'(sel_tally);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
            winner_q   <= '0;
            tie_q      <= 1'b1;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            tally_q    <= tally_d;
            winner_q   <= winner_d;
            tie_q      <= tie_d;
            led_q      <= led_d;
        end
    end

    assign led    = led_q;
    assign winner = winner_q;
    assign tie    = tie_q;
    assign busy   = (state_q == ST_LOCK);

`ifdef VM_REJECT_COUNT_EN
    logic [CNT_W-1:0] rejects_q, rejects_d;

    // One count per cycle in which any qualified press is ignored.
    always_comb begin
        rejects_d = rejects_q;
        if ((|valid) && !accept && (rejects_q != '1)) begin
            rejects_d = rejects_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rejects_q <= '0;
        else       rejects_q <= rejects_d;
    end

    assign rejects = rejects_q;
`endif

endmodule

// File: tb/tb_vm_ballot_core.sv
// ---------------------------------------------------------------------------
// tb_vm_ballot_core
// Bench for vm_ballot_core with DEBOUNCE_CYC=4, LOCK_CYC=8. A behavioural
// model tracks ballots from the button/mode inputs and is compared against
// the DUT on every falling edge outside reset; directed scenarios add literal
// expectations. VM_REJECT_COUNT_EN, if defined, also enables the reject port.
// ---------------------------------------------------------------------------
module tb_vm_ballot_core;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int LW = 8;
    localparam int DB = 4;
    localparam int LC = 8;
    localparam int IW = 2;

    logic          clock  = 1'b0;
    logic          reset  = 1'b1;
    logic          mode   = 1'b0;
    logic [NC-1:0] button = '0;
    logic [IW-1:0] sel    = '0;
    logic [LW-1:0] led;
    logic [IW-1:0] winner;
    logic          tie;
    logic          busy;
`ifdef VM_REJECT_COUNT_EN
    logic [CW-1:0] rejects;
`endif

    always #5 clock = ~clock;

    vm_ballot_core #(
        .NUM_CAND    (NC),
        .CNT_W       (CW),
        .LED_W       (LW),
        .DEBOUNCE_CYC(DB),
        .LOCK_CYC    (LC)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .mode   (mode),
        .button (button),
        .sel    (sel),
        .led    (led),
        .winner (winner),
        .tie    (tie),
        .busy   (busy)
`ifdef VM_REJECT_COUNT_EN
        ,
        .rejects(rejects)
`endif
    );

    int nChecks = 0;
    int nFail   = 0;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural ballot model: press runs, ballot state, tallies and leader.
    int  mRun    [NC];
    bit  mArmed  [NC];
    int  mTally  [NC];
    int  mWinner, mState, mLockLeft, mAck, mRejects, mLed, mLead;
    bit  mTie;
    int  nValid, vCand;
    bit  acc;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NC; i++) begin
                mRun[i] = 0; mArmed[i] = 0; mTally[i] = 0;
            end
            mWinner = 0; mTie = 1; mState = 0; mLockLeft = 0;
            mAck = 0; mRejects = 0; mLed = 0;
        end else begin
            nValid = 0; vCand = 0;
            for (int i = 0; i < NC; i++) begin
                if (mArmed[i] && mRun[i] == DB) begin
                    nValid++; vCand = i;
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (!button[i]) begin
                    mRun[i] = 0; mArmed[i] = 1;
                end else if (mArmed[i]) begin
                    mRun[i]++;
                end
            end
            acc = (mState == 0) && (mode == 1'b0) && (nValid == 1);
            if (nValid > 0 && !acc && mRejects < 255) mRejects++;
            if (mode) begin
                mState = 2;
            end else if (mState == 2) begin
                mState = 0;
            end else if (mState == 1) begin
                mLockLeft--;
                if (mLockLeft == 0) mState = 0;
            end else if (acc) begin
                mState = 1; mLockLeft = LC; mAck = vCand;
                if (mTally[vCand] < 255) begin
                    mLead = mTally[mWinner];
                    mTally[vCand]++;
                    if (mTally[vCand] > mLead) begin
                        mWinner = vCand; mTie = 0;
                    end else if (mTally[vCand] == mLead && vCand != mWinner) begin
                        mTie = 1;
                    end
                end
            end
            if (mState == 1)      mLed = 1 << (mAck % LW);
            else if (mState == 2) mLed = (int'(sel) < NC) ? mTally[sel] : 0;
            else                  mLed = 0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("led",    int'(led),    mLed);
            checkOutput("winner", int'(winner), mWinner);
            checkOutput("tie",    int'(tie),    int'(mTie));
            checkOutput("busy",   int'(busy),   int'(mState == 1));
`ifdef VM_REJECT_COUNT_EN
            checkOutput("rejects", int'(rejects), mRejects);
`endif
        end
    end

    // Length of the most recent completed busy run.
    int busyRun = 0;
    int lastBusyRun = 0;
    always @(negedge clock) begin
        if (reset) busyRun = 0;
        else if (busy) busyRun++;
        else if (busyRun != 0) begin
            lastBusyRun = busyRun;
            busyRun = 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [NC-1:0] b, input logic [IW-1:0] s);
        mode   = m;
        button = b;
        sel    = s;
    endtask

    task automatic pressFor(input logic [NC-1:0] b, input int hold);
        applyStimulus(1'b0, b, '0);
        tick(hold);
        applyStimulus(1'b0, '0, '0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_led"},    int'(led),    0);
        checkOutput({tag, "_winner"}, int'(winner), 0);
        checkOutput({tag, "_tie"},    int'(tie),    1);
        checkOutput({tag, "_busy"},   int'(busy),   0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, '0);
        reset = 1'b1;
        tick(1);
        checkResetValues("reset");
        reset = 1'b0;
        tick(2);
    endtask

    task automatic showTally(input int cand, input int expected, input string name);
        applyStimulus(1'b1, '0, IW'(cand));
        tick(1);
        checkOutput(name, int'(led), expected);
        applyStimulus(1'b0, '0, '0);
        tick(1);
    endtask

    initial begin
        // Single vote for candidate 2.
        doReset();
        applyStimulus(1'b0, 4'b0100, '0);
        tick(6);
        checkOutput("t1_busy",   int'(busy),   1);
        checkOutput("t1_led",    int'(led),    8'h04);
        checkOutput("t1_winner", int'(winner), 2);
        checkOutput("t1_tie",    int'(tie),    0);
        applyStimulus(1'b0, '0, '0);
        tick(10);
        checkOutput("t1_busy_len", lastBusyRun, 8);
        showTally(2, 1, "t1_tally2");

        // Simultaneous qualification is rejected.
        doReset();
        pressFor(4'b0011, 6);
        tick(4);
        checkOutput("t2_busy", int'(busy), 0);
        showTally(0, 0, "t2_tally0");
        showTally(1, 0, "t2_tally1");
`ifdef VM_REJECT_COUNT_EN
        checkOutput("t2_rejects", int'(rejects), 1);
`endif

        // Vote 1, press 3 in lockout (ignored), then vote 3.
        doReset();
        pressFor(4'b0010, 6);
        pressFor(4'b1000, 5);
        tick(6);
        pressFor(4'b1000, 6);
        tick(10);
        checkOutput("t3_winner", int'(winner), 1);
        checkOutput("t3_tie",    int'(tie),    1);
        showTally(1, 1, "t3_tally1");
        showTally(3, 1, "t3_tally3");

        // Saturate candidate 0, then one more vote.
        doReset();
        for (int v = 0; v < 255; v++) begin
            pressFor(4'b0001, 5);
            tick(9);
        end
        checkOutput("t4_winner", int'(winner), 0);
        checkOutput("t4_tie",    int'(tie),    0);
        pressFor(4'b0001, 5);
        checkOutput("t4_busy_sat",   int'(busy),   1);
        checkOutput("t4_winner_sat", int'(winner), 0);
        checkOutput("t4_tie_sat",    int'(tie),    0);
        applyStimulus(1'b1, '0, '0);
        tick(1);
        checkOutput("t4_led_ff", int'(led), 8'hFF);
        checkOutput("t4_busy_abandon", int'(busy), 0);
        applyStimulus(1'b0, '0, '0);
        tick(2);

        // Result mode abandons a lockout at cycle 3.
        doReset();
        pressFor(4'b0100, 5);
        tick(2);
        applyStimulus(1'b1, '0, '0);
        tick(1);
        checkOutput("t5_busy_drop", int'(busy), 0);
        applyStimulus(1'b0, '0, '0);
        tick(1);
        pressFor(4'b0010, 5);
        checkOutput("t5_busy_again", int'(busy),   1);
        checkOutput("t5_winner",     int'(winner), 2);
        checkOutput("t5_tie",        int'(tie),    1);
        tick(10);

        // Reset while button 0 is mid-debounce and kept held.
        doReset();
        applyStimulus(1'b0, 4'b0001, '0);
        tick(2);
        reset = 1'b1;
        #1;
        checkResetValues("t6_async");
        tick(1);
        reset = 1'b0;
        tick(10);
        checkOutput("t6_no_vote", int'(busy), 0);
        showTally(0, 0, "t6_tally0");
        pressFor(4'b0001, 5);
        checkOutput("t6_repress", int'(busy), 1);
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/vm_ballot_core.md
# vm_ballot_core

Parametrised successor to the four-button voting machine top: NUM_CAND debounced candidate buttons, one tally counter per candidate, and a running leader/tie tracker. A post-vote lockout prevents double votes, and a result mode displays any selected tally on the LED bus. It is the top-level ballot engine of the voting design. Buttons come straight from pads; `led`, `winner` and `tie` drive the board display.

## Interface
Parameters:
- NUM_CAND, 4: number of candidates/buttons, ≥2.
- CNT_W, 8: tally counter width.
- LED_W, 8: LED bus width.
- DEBOUNCE_CYC, 10: consecutive high samples required to qualify a press, ≥1.
- LOCK_CYC, 100: lockout length after an accepted vote, ≥1.
- IDX_W, $clog2(NUM_CAND): derived candidate-index width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mode  in  1  0 = voting, 1 = result display.
- button  in  NUM_CAND  raw candidate buttons, active-high.
- sel  in  IDX_W  candidate whose tally is shown in result mode.
- led  out  LED_W  display bus.
- winner  out  IDX_W  index of the current leader.
- tie  out  1  leader's tally is shared by at least one other candidate.
- busy  out  1  lockout in progress.

## Operation
- Button qualifier per channel:
  - A counter increments while `button` is high and clears when it is low.
  - The cycle the count reaches DEBOUNCE_CYC, `valid[i]` pulses for exactly 1 cycle.
  - No further pulse occurs until `button` has been low for ≥1 cycle.
- FSM states and transitions:
  - IDLE → LOCK: `mode`=0 and exactly one `valid` bit is set. That tally increments.
  - LOCK → IDLE: LOCK_CYC cycles elapse.
  - Any state → RESULT: `mode`=1.
  - RESULT → IDLE: `mode`=0.
  - `mode` has priority: rising `mode` during LOCK abandons the lockout.
- Rejections, with no tally change:
  - two or more `valid` bits in the same cycle;
  - any `valid` in LOCK or RESULT.
- Tallies saturate at 2^CNT_W−1. An increment at saturation is dropped and leaves winner/tie unchanged.
- Leader tracking happens on each accepted increment of candidate c, where L is the current leader's tally and c's new tally is compared against it:
  - new tally > L: `winner`=c, `tie`=0;
  - new tally == L and c≠winner: `tie`=1, `winner` unchanged;
  - otherwise: no change.
- LED output:
  - IDLE: all zeros.
  - LOCK: bit i is set for the candidate just accepted (acknowledge); i is reduced mod LED_W.
  - RESULT: tally[`sel`], zero-extended or truncated to LED_W. A `sel` ≥ NUM_CAND displays 0.

## Timing
- Reset values:
  - all tallies 0, state IDLE;
  - `led`=0, `winner`=0, `tie`=1 (all tallies equal at 0), `busy`=0;
  - qualifier counters 0.
- `button` sampled high on DEBOUNCE_CYC consecutive edges → `valid` asserts the cycle after the last of those edges.
- `valid` → tally, `winner`, `tie`, `busy`=1 and LOCK `led` all update on the next edge (1-cycle latency).
- `busy` is high for exactly LOCK_CYC cycles.
- Result-mode `led` is registered: a change on `sel`/`mode` appears 1 cycle later.
- Reset mid-lockout or mid-debounce: everything clears immediately; a held button must be released and re-pressed before it can vote.

## Configuration
- Macro `VM_REJECT_COUNT_EN`.
- When defined:
  - adds output `rejects` [CNT_W], a saturating count of rejected `valid` pulses (simultaneous, locked-out, or in result mode);
  - reset value 0;
  - increments by 1 per rejecting cycle, regardless of how many bits were set.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

## Structure
- Package `vm_pkg` holds:
  - the FSM state enum (IDLE, LOCK, RESULT);
  - mode encoding constants (MODE_VOTE=0, MODE_RESULT=1).
- Sub-module `vm_button_qual` (one instance per candidate, via generate) holds the per-channel debounce counter, pulse and release-rearm logic.
- Tallies, FSM and leader tracker live in the top.

## Test plan
(defaults except DEBOUNCE_CYC=4, LOCK_CYC=8)
- Hold button[2] for 6 cycles → one `valid` pulse; tally2=1, `winner`=2, `tie`=0, `busy` high for 8 cycles, `led`=8'b0000_0100 during lockout.
- Buttons 0 and 1 qualify in the same cycle → tallies unchanged, `busy` stays 0; `rejects`=1 with the macro defined.
- Vote cand1, then press cand3 during lockout, then vote cand3 after lockout → tally1=1, tally3=1, `winner`=1, `tie`=1.
- Force tally0 to 255 by repeated votes, vote cand0 again → stays 255, `winner`/`tie` unchanged; `mode`=1, `sel`=0 → `led`=8'hFF one cycle later.
- Assert `mode`=1 at lockout cycle 3 → `busy` drops next cycle; return `mode`=0 and vote → accepted immediately.
- Assert `reset` while button[0] is held mid-debounce → all outputs at reset values; keeping button[0] held after reset release produces no vote.
